// File: rtl/adc_spi_multi_rx.sv
// ============================================================================
// Module   : adc_spi_multi_rx
// Purpose  : Multi-channel ADC serial receiver. It frames all channels with a
//            shared active-low SYNC, shifts a command out on SDI and captures
//            one sample per SDO line, with a valid/ready output and sticky
//            overrun. Optional macro ADC_SPI_SIGN_EXT_EN adds a per-channel
//            SIGN output.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module adc_spi_multi_rx #(
    parameter int CHANNELS   = 2,
    parameter int FRAME_BITS = 16,
    parameter int LEAD_BITS  = 4,
    parameter int DATA_BITS  = 12,
    parameter int GAP_CYCLES = 2
) (
    input  logic                            SCLK,
    input  logic                            RST,
    input  logic                            EN,
    input  logic [FRAME_BITS-1:0]           CMD,
    input  logic [CHANNELS-1:0]             SDO,
    output logic                            SYNC,
    output logic                            SDI,
    output logic [CHANNELS*DATA_BITS-1:0]   DATA,
    output logic                            DATA_VALID,
    input  logic                            DATA_READY,
    output logic                            OVERRUN,
`ifdef ADC_SPI_SIGN_EXT_EN
    output logic [CHANNELS-1:0]             SIGN,
`endif
    output logic                            BUSY
);

    localparam int BCW = $clog2(FRAME_BITS + 1);
    localparam int GCW = $clog2(GAP_CYCLES + 1);

    localparam logic [BCW-1:0] c_last_bit = BCW'(FRAME_BITS - 1);
    localparam logic [BCW-1:0] c_lead     = BCW'(LEAD_BITS);
    localparam logic [BCW-1:0] c_dbits    = BCW'(DATA_BITS);
    localparam logic [GCW-1:0] c_last_gap = GCW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t                               r_state;
    state_t                               w_state_nxt;
    logic                                 w_start;
    logic                                 w_done;
    logic                                 w_in_win;
    logic [BCW-1:0]                       r_bit_cnt;
    logic [GCW-1:0]                       r_gap_cnt;
    logic [FRAME_BITS-1:0]                r_cmd;
    logic                                 r_sync;
    logic                                 r_sdi;
    logic                                 r_valid;
    logic                                 r_overrun;
    logic [CHANNELS*DATA_BITS-1:0]        r_data;
    logic [CHANNELS-1:0][DATA_BITS-1:0]   r_sr;
    logic [CHANNELS-1:0][DATA_BITS-1:0]   w_sr_nxt;

    always_ff @(posedge SCLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (EN) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_bit_cnt == c_last_bit) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == c_last_gap) begin
                    if (EN) begin
                        w_start     = 1'b1;
                        w_state_nxt = S_SHIFT;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Only the DATA_BITS window is kept; bits before it wrap to a large
    // unsigned offset and fail the compare, bits after it fail naturally.
    assign w_in_win = (r_state == S_SHIFT) && ((r_bit_cnt - c_lead) < c_dbits);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign w_sr_nxt[c] = w_in_win ? {r_sr[c][DATA_BITS-2:0], SDO[c]} : r_sr[c];
    end

    always_ff @(posedge SCLK) begin
        if (RST) begin
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_cmd     <= '0;
            r_sync    <= 1'b1;
            r_sdi     <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_data    <= '0;
            r_sr      <= '0;
        end else begin
            if (w_start) begin
                r_sync    <= 1'b0;
                r_sdi     <= CMD[FRAME_BITS-1];
                r_cmd     <= {CMD[FRAME_BITS-2:0], 1'b0};
                r_bit_cnt <= '0;
            end else if (r_state == S_SHIFT) begin
                r_sr      <= w_sr_nxt;
                r_bit_cnt <= r_bit_cnt + 1'b1;
                if (w_done) begin
                    r_sync <= 1'b1;
                    r_sdi  <= 1'b0;
                end else begin
                    r_sdi  <= r_cmd[FRAME_BITS-1];
                    r_cmd  <= r_cmd << 1;
                end
            end

            if (w_done) begin
                r_gap_cnt <= '0;
            end else if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end

            // A completing frame wins over a same-edge accept.
            if (w_done) begin
                r_data  <= w_sr_nxt;
                r_valid <= 1'b1;
                if (r_valid && !DATA_READY) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && DATA_READY) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef ADC_SPI_SIGN_EXT_EN
    logic [CHANNELS-1:0] r_sign;

    always_ff @(posedge SCLK) begin
        if (RST) begin
            r_sign <= '0;
        end else if (w_done) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_sign[c] <= w_sr_nxt[c][DATA_BITS-1];
            end
        end
    end

    assign SIGN = r_sign;
`endif

    assign SYNC       = r_sync;
    assign SDI        = r_sdi;
    assign DATA       = r_data;
    assign DATA_VALID = r_valid;
    assign OVERRUN    = r_overrun;
    assign BUSY       = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_adc_spi_multi_rx.sv
// ============================================================================
// Module   : tb_adc_spi_multi_rx
// Purpose  : Bench for adc_spi_multi_rx, default and wide configurations.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_adc_spi_multi_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_en, a_sync, a_sdi, a_valid, a_ready, a_ovr, a_busy;
    logic [15:0] a_cmd;
    logic [1:0]  a_sdo;
    logic [23:0] a_data;

    logic        b_en, b_sync, b_sdi, b_valid, b_ready, b_ovr, b_busy;
    logic [23:0] b_cmd;
    logic [3:0]  b_sdo;
    logic [63:0] b_data;

`ifdef ADC_SPI_SIGN_EXT_EN
    logic [1:0] a_sign;
    logic [3:0] b_sign;
`endif

    adc_spi_multi_rx u_dut_a (
        .SCLK(clk), .RST(rst), .EN(a_en), .CMD(a_cmd), .SDO(a_sdo),
        .SYNC(a_sync), .SDI(a_sdi), .DATA(a_data), .DATA_VALID(a_valid),
        .DATA_READY(a_ready), .OVERRUN(a_ovr),
`ifdef ADC_SPI_SIGN_EXT_EN
        .SIGN(a_sign),
`endif
        .BUSY(a_busy)
    );

    adc_spi_multi_rx #(
        .CHANNELS(4), .FRAME_BITS(24), .LEAD_BITS(2), .DATA_BITS(16), .GAP_CYCLES(2)
    ) u_dut_b (
        .SCLK(clk), .RST(rst), .EN(b_en), .CMD(b_cmd), .SDO(b_sdo),
        .SYNC(b_sync), .SDI(b_sdi), .DATA(b_data), .DATA_VALID(b_valid),
        .DATA_READY(b_ready), .OVERRUN(b_ovr),
`ifdef ADC_SPI_SIGN_EXT_EN
        .SIGN(b_sign),
`endif
        .BUSY(b_busy)
    );

    int checks = 0;
    int errors = 0;
    int dv_cycles = 0;

    // Handshake model for the default instance, driven by the rules directly.
    bit          m_valid = 1'b0;
    bit          m_ovr   = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_a(input bit done_edge);
        if (done_edge) begin
            if (m_valid && !a_ready) m_ovr = 1'b1;
            m_valid = 1'b1;
        end else if (m_valid && a_ready) begin
            m_valid = 1'b0;
        end
        tick();
        if (a_valid) dv_cycles++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_sync"},  a_sync,  1'b1);
        check({tag, "_sdi"},   a_sdi,   1'b0);
        check({tag, "_data"},  a_data,  24'h0);
        check({tag, "_valid"}, a_valid, 1'b0);
        check({tag, "_ovr"},   a_ovr,   1'b0);
        check({tag, "_busy"},  a_busy,  1'b0);
`ifdef ADC_SPI_SIGN_EXT_EN
        check({tag, "_sign"},  a_sign,  2'b0);
`endif
    endtask

    // Runs one frame on the default instance. The ADC word for channel c is
    // sent MSB-first; the sample is word bits [11:0] (16-bit frame, 4 lead bits).
    task automatic frame_a(input logic [15:0] cmd, input logic [15:0] w0, input logic [15:0] w1,
                           input bit drop_en, input bit rdy_last, input string tag,
                           output int gap_n);
        logic [15:0] sdi_seq;
        logic [23:0] exp;
        int          low_n;
        gap_n   = 0;
        low_n   = 0;
        sdi_seq = '0;
        exp     = {w1[11:0], w0[11:0]};
        while (a_sync === 1'b1 && gap_n < 40) begin
            tick_a(1'b0);
            gap_n++;
        end
        check({tag, "_start"}, a_sync, 1'b0);
        for (int k = 0; k < 16; k++) begin
            sdi_seq[15-k] = a_sdi;
            if (a_sync === 1'b0) low_n++;
            a_sdo = {w1[15-k], w0[15-k]};
            if (k == 0 && drop_en) a_en = 1'b0;
            if (k == 15 && rdy_last) a_ready = 1'b1;
            tick_a(k == 15);
        end
        check({tag, "_sdi_seq"}, sdi_seq, cmd);
        check({tag, "_low_n"},   low_n,   16);
        check({tag, "_sync_hi"}, a_sync,  1'b1);
        check({tag, "_sdi0"},    a_sdi,   1'b0);
        check({tag, "_data"},    a_data,  exp);
        check({tag, "_valid"},   a_valid, m_valid);
        check({tag, "_ovr"},     a_ovr,   m_ovr);
`ifdef ADC_SPI_SIGN_EXT_EN
        check({tag, "_sign"},    a_sign,  {exp[23], exp[11]});
`endif
    endtask

    // Wide instance: 24-bit frame, 2 lead bits, 16-bit samples on 4 channels.
    task automatic frame_b(input logic [23:0] cmd, input logic [3:0][23:0] w, input string tag);
        logic [23:0] sdi_seq;
        logic [63:0] exp;
        int          low_n;
        int          wait_n;
        wait_n  = 0;
        low_n   = 0;
        sdi_seq = '0;
        for (int c = 0; c < 4; c++) exp[c*16 +: 16] = w[c][21 -: 16];
        b_cmd = cmd;
        b_en  = 1'b1;
        while (b_sync === 1'b1 && wait_n < 40) begin
            tick();
            wait_n++;
        end
        check({tag, "_start"}, b_sync, 1'b0);
        for (int k = 0; k < 24; k++) begin
            sdi_seq[23-k] = b_sdi;
            if (b_sync === 1'b0) low_n++;
            for (int c = 0; c < 4; c++) b_sdo[c] = w[c][23-k];
            if (k == 0) b_en = 1'b0;
            tick();
        end
        check({tag, "_sdi_seq"}, sdi_seq, cmd);
        check({tag, "_low_n"},   low_n,   24);
        check({tag, "_sync_hi"}, b_sync,  1'b1);
        check({tag, "_data"},    b_data,  exp);
        check({tag, "_valid"},   b_valid, 1'b1);
`ifdef ADC_SPI_SIGN_EXT_EN
        check({tag, "_sign"},    b_sign,  {exp[63], exp[47], exp[31], exp[15]});
`endif
        for (int i = 0; i < 4; i++) tick();
        check({tag, "_idle_busy"},  b_busy,  1'b0);
        check({tag, "_idle_valid"}, b_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0]      cmd, w0, w1;
        logic [3:0][23:0] wb;
        int               gap;

        rst = 1'b1;
        a_en = 1'b0; a_cmd = '0; a_sdo = '0; a_ready = 1'b0;
        b_en = 1'b0; b_cmd = '0; b_sdo = '0; b_ready = 1'b1;

        // Power-on reset
        do_reset();
        check_reset_a("por");
        check("por_b_sync", b_sync, 1'b1);
        check("por_b_busy", b_busy, 1'b0);

        // Directed single frame with EN pulse
        a_cmd = 16'hA5C3;
        a_en  = 1'b1;
        frame_a(16'hA5C3, 16'h0AB0, 16'h054F, 1'b1, 1'b0, "single", gap);
        check("single_busy_gap", a_busy, 1'b1);
        a_ready = 1'b1;
        tick_a(1'b0);
        check("single_accept", a_valid, 1'b0);
        for (int i = 0; i < 3; i++) tick_a(1'b0);
        check("single_idle_busy", a_busy, 1'b0);
        check("single_idle_sync", a_sync, 1'b1);

        // Continuous framing, consumer always ready
        dv_cycles = 0;
        a_ready   = 1'b1;
        a_en      = 1'b1;
        for (int f = 0; f < 8; f++) begin
            cmd = 16'($urandom); w0 = 16'($urandom); w1 = 16'($urandom);
            a_cmd = cmd;
            frame_a(cmd, w0, w1, f == 7, 1'b0, "cont", gap);
            if (f > 0) check("cont_gap", gap, 2);
        end
        for (int i = 0; i < 5; i++) tick_a(1'b0);
        check("cont_dv_cycles", dv_cycles, 8);
        check("cont_idle_busy", a_busy, 1'b0);

        // Overrun: two frames without consumption
        a_ready = 1'b0;
        a_en    = 1'b1;
        for (int f = 0; f < 2; f++) begin
            cmd = 16'($urandom); w0 = 16'($urandom); w1 = 16'($urandom);
            a_cmd = cmd;
            frame_a(cmd, w0, w1, f == 1, 1'b0, "ovr", gap);
        end
        check("ovr_set", a_ovr, 1'b1);
        a_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick_a(1'b0);
        check("ovr_sticky", a_ovr, 1'b1);
        check("ovr_valid_clr", a_valid, 1'b0);
        do_reset();
        check("ovr_rst_clr", a_ovr, 1'b0);

        // Accept on the same edge as a completing frame
        a_ready = 1'b0;
        a_en    = 1'b1;
        for (int f = 0; f < 2; f++) begin
            cmd = 16'($urandom); w0 = 16'($urandom) | 16'h0001; w1 = 16'($urandom);
            a_cmd = cmd;
            frame_a(cmd, w0, w1, f == 1, f == 1, "simul", gap);
        end
        check("simul_valid", a_valid, 1'b1);
        check("simul_ovr", a_ovr, 1'b0);
        tick_a(1'b0);
        check("simul_accept", a_valid, 1'b0);
        for (int i = 0; i < 3; i++) tick_a(1'b0);

        // Reset in the middle of a frame
        a_cmd = 16'hFFFF;
        a_en  = 1'b1;
        a_sdo = 2'b11;
        tick_a(1'b0);
        a_en = 1'b0;
        for (int i = 0; i < 5; i++) tick_a(1'b0);
        check("rstmid_sync_low", a_sync, 1'b0);
        check("rstmid_busy", a_busy, 1'b1);
        do_reset();
        check_reset_a("rstmid");
        tick_a(1'b0);
        check("rstmid_stay_idle", a_busy, 1'b0);

        // Wide configuration
        wb[0] = 24'h3F_A5_C0; wb[1] = 24'hC0_5A_3F; wb[2] = 24'h12_34_56; wb[3] = 24'hFF_FF_FF;
        frame_b(24'hC3_A5_96, wb, "wide_dir");
        for (int c = 0; c < 4; c++) wb[c] = 24'($urandom);
        frame_b(24'($urandom), wb, "wide_rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
